// File: rtl/cache_ctr_regs.sv
// Data-cache control/status registers: IO region table, global enable and
// a small command sequencer that issues init/wb/clear to the cache controller.

`ifndef CACHE_CTR_CMD_NOP
`define CACHE_CTR_CMD_NOP   3'd0
`endif
`ifndef CACHE_CTR_CMD_INIT
`define CACHE_CTR_CMD_INIT  3'd1
`endif
`ifndef CACHE_CTR_CMD_CLEAR
`define CACHE_CTR_CMD_CLEAR 3'd2
`endif
`ifndef CACHE_CTR_CMD_WB
`define CACHE_CTR_CMD_WB    3'd3
`endif

module cache_ctr_region #(
  parameter int BW = 22
) (
  input  logic          valid,
  input  logic [BW-1:0] low,
  input  logic [BW-1:0] high,
  input  logic [BW-1:0] addr,
  output logic          hit
);
  // An inverted range (low > high) can never satisfy both bounds.
  assign hit = valid && (addr >= low) && (addr <= high);
endmodule

module cache_ctr_regs #(
  parameter int REGION_NUM   = 4,
  parameter int GRAN_BITS    = 10,
  parameter bit IO_MSB_FORCE = 1'b1
) (
  input  logic        clk,
  input  logic        rest,
  input  logic [31:0] s0_address,
  input  logic [3:0]  s0_byteEnable,
  input  logic        s0_read,
  output logic [31:0] s0_readData,
  input  logic        s0_write,
  input  logic [31:0] s0_writeData,
  output logic        s0_waitRequest,
  output logic        s0_readDataValid,
  input  logic [31:0] address,
  output logic        isIOAddrBlock,
  output logic        isEnableCache,
  output logic [2:0]  cmd,
  input  logic        cmd_ready
);
  localparam int AW = $clog2(8 + 8*REGION_NUM);
  localparam int NW = AW - 2;
  localparam int BW = 32 - GRAN_BITS;

  localparam logic [2:0] CMD_NOP   = `CACHE_CTR_CMD_NOP;
  localparam logic [2:0] CMD_INIT  = `CACHE_CTR_CMD_INIT;
  localparam logic [2:0] CMD_CLEAR = `CACHE_CTR_CMD_CLEAR;
  localparam logic [2:0] CMD_WB    = `CACHE_CTR_CMD_WB;

  typedef enum logic {ST_WAIT, ST_IDLE} state_t;

  state_t                         state;
  logic                           en, pend_wb, pend_clr, done;
  logic [REGION_NUM-1:0]          rvalid;
  logic [REGION_NUM-1:0][BW-1:0]  low_bnd, high_bnd;
  logic [REGION_NUM-1:0]          hit;
  logic [NW-1:0]                  widx;
  logic [31:0]                    rdata;
  logic                           ctrl_wr, stat_wr;
  logic                           wb_set, clr_set, take_wb, take_clr, done_set;
  logic                           unused_ok;

  assign widx    = s0_address[AW-1:2];
  assign ctrl_wr = s0_write && (widx == NW'(0));
  assign stat_wr = s0_write && (widx == NW'(1));

  assign wb_set   = ctrl_wr && s0_writeData[17];
  // Dropping EN invalidates the cache contents, so it implies a clear.
  assign clr_set  = ctrl_wr && (s0_writeData[18] || (en && !s0_writeData[16]));
  assign take_wb  = (state == ST_IDLE) && pend_wb;
  assign take_clr = (state == ST_IDLE) && !pend_wb && pend_clr;
  assign done_set = (state == ST_WAIT) && cmd_ready;

  assign s0_waitRequest = 1'b0;
  assign isEnableCache  = en;

  genvar g;
  generate
    for (g = 0; g < REGION_NUM; g++) begin : g_rgn
      cache_ctr_region #(.BW(BW)) u_rgn (
        .valid (rvalid[g]),
        .low   (low_bnd[g]),
        .high  (high_bnd[g]),
        .addr  (address[31:GRAN_BITS]),
        .hit   (hit[g])
      );
    end
  endgenerate

  assign isIOAddrBlock = (IO_MSB_FORCE && address[31]) || (|hit);

  always_comb begin
    rdata = '0;
    if (widx == NW'(0))
      rdata[16] = en;
    else if (widx == NW'(1))
      rdata = {25'd0, cmd, pend_clr, pend_wb, done, (state != ST_IDLE)};
    for (int i = 0; i < REGION_NUM; i++) begin
      if (widx == NW'(2 + 2*i)) rdata = {low_bnd[i], {(GRAN_BITS-1){1'b0}}, rvalid[i]};
      if (widx == NW'(3 + 2*i)) rdata = {high_bnd[i], {GRAN_BITS{1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      s0_readData      <= '0;
      s0_readDataValid <= 1'b0;
    end else begin
      s0_readDataValid <= s0_read;
      if (s0_read) s0_readData <= rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      rvalid   <= '0;
      low_bnd  <= '0;
      high_bnd <= '0;
    end else begin
      for (int i = 0; i < REGION_NUM; i++) begin
        if (s0_write && widx == NW'(2 + 2*i)) begin
          low_bnd[i] <= s0_writeData[31:GRAN_BITS];
          rvalid[i]  <= s0_writeData[0];
        end
        if (s0_write && widx == NW'(3 + 2*i))
          high_bnd[i] <= s0_writeData[31:GRAN_BITS];
      end
    end
  end

  // Request bits: a new request in the consume cycle survives (set wins).
  always_ff @(posedge clk) begin
    if (rest) begin
      state    <= ST_WAIT;
      cmd      <= CMD_INIT;
      en       <= 1'b1;
      pend_wb  <= 1'b0;
      pend_clr <= 1'b0;
      done     <= 1'b0;
    end else begin
      if (ctrl_wr) en <= s0_writeData[16];
      pend_wb  <= wb_set  || (pend_wb  && !take_wb);
      pend_clr <= clr_set || (pend_clr && !take_clr);
      done     <= done_set || (done && !(stat_wr && s0_writeData[1]));
      case (state)
        ST_IDLE: begin
          if (pend_wb) begin
            cmd   <= CMD_WB;
            state <= ST_WAIT;
          end else if (pend_clr) begin
            cmd   <= CMD_CLEAR;
            state <= ST_WAIT;
          end else begin
            cmd <= CMD_NOP;
          end
        end
        default: begin
          if (cmd_ready) begin
            cmd   <= CMD_NOP;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign unused_ok = ^{s0_byteEnable, s0_address, s0_writeData, address};
endmodule

// File: tb/tb_cache_ctr_regs.sv
// Directed bench for cache_ctr_regs: reset, regions, command sequencing, bus.

`ifndef CACHE_CTR_CMD_NOP
`define CACHE_CTR_CMD_NOP   3'd0
`endif
`ifndef CACHE_CTR_CMD_INIT
`define CACHE_CTR_CMD_INIT  3'd1
`endif
`ifndef CACHE_CTR_CMD_CLEAR
`define CACHE_CTR_CMD_CLEAR 3'd2
`endif
`ifndef CACHE_CTR_CMD_WB
`define CACHE_CTR_CMD_WB    3'd3
`endif

module tb_cache_ctr_regs;
  logic        clk = 1'b0;
  logic        rest;
  logic [31:0] s0_address;
  logic [3:0]  s0_byteEnable;
  logic        s0_read;
  logic [31:0] s0_readData;
  logic        s0_write;
  logic [31:0] s0_writeData;
  logic        s0_waitRequest;
  logic        s0_readDataValid;
  logic [31:0] address;
  logic        isIOAddrBlock;
  logic        isEnableCache;
  logic [2:0]  cmd;
  logic        cmd_ready;

  int checks = 0;
  int failures = 0;

  localparam logic [31:0] NOP = 32'(`CACHE_CTR_CMD_NOP);
  localparam logic [31:0] INI = 32'(`CACHE_CTR_CMD_INIT);
  localparam logic [31:0] CLR = 32'(`CACHE_CTR_CMD_CLEAR);
  localparam logic [31:0] WB  = 32'(`CACHE_CTR_CMD_WB);

  cache_ctr_regs dut (
    .clk(clk), .rest(rest), .s0_address(s0_address), .s0_byteEnable(s0_byteEnable),
    .s0_read(s0_read), .s0_readData(s0_readData), .s0_write(s0_write),
    .s0_writeData(s0_writeData), .s0_waitRequest(s0_waitRequest),
    .s0_readDataValid(s0_readDataValid), .address(address),
    .isIOAddrBlock(isIOAddrBlock), .isEnableCache(isEnableCache),
    .cmd(cmd), .cmd_ready(cmd_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    s0_address = a; s0_writeData = d; s0_write = 1'b1;
    tick();
    s0_write = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    s0_address = a; s0_read = 1'b1;
    tick();
    s0_read = 1'b0;
    check({tag, "_valid"}, 32'(s0_readDataValid), 32'd1);
    check(tag, s0_readData, exp);
  endtask

  task automatic io(input string tag, input logic [31:0] a, input logic exp);
    address = a;
    #1;
    check(tag, 32'(isIOAddrBlock), 32'(exp));
  endtask

  task automatic ready_pulse();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
  endtask

  initial begin
    rest = 1'b1; s0_address = '0; s0_byteEnable = 4'hF; s0_read = 1'b0;
    s0_write = 1'b0; s0_writeData = '0; address = '0; cmd_ready = 1'b0;
    tick(); tick();
    rest = 1'b0;

    // Reset state
    check("rst_cmd", 32'(cmd), INI);
    check("rst_en", 32'(isEnableCache), 32'd1);
    check("rst_rdata", s0_readData, 32'd0);
    check("rst_rvalid", 32'(s0_readDataValid), 32'd0);
    check("rst_wait", 32'(s0_waitRequest), 32'd0);
    io("rst_io_lo", 32'h0000_5000, 1'b0);
    io("rst_io_msb", 32'h8000_0000, 1'b1);
    rd("rst_status", 32'h4, 32'h0000_0011);
    tick();
    check("rvalid_drop", 32'(s0_readDataValid), 32'd0);
    ready_pulse();
    check("init_done_cmd", 32'(cmd), NOP);
    rd("init_status", 32'h4, 32'h0000_0002);

    // Regions
    wr(32'h10, 32'h0000_4001);
    wr(32'h14, 32'h0000_7C00);
    io("r1_in", 32'h0000_5000, 1'b1);
    io("r1_above", 32'h0000_8000, 1'b0);
    io("r1_low_edge", 32'h0000_4000, 1'b1);
    io("r1_high_edge", 32'h0000_7FFF, 1'b1);
    io("r1_below", 32'h0000_3FFF, 1'b0);
    rd("low1_rb", 32'h10, 32'h0000_4001);
    rd("high1_rb", 32'h14, 32'h0000_7C00);
    wr(32'h10, 32'h0000_4000);
    io("r1_invalid", 32'h0000_5000, 1'b0);
    io("msb_force", 32'h8000_0000, 1'b1);
    wr(32'h18, 32'h0000_8001);
    wr(32'h1C, 32'h0000_4000);
    io("r2_inverted", 32'h0000_6000, 1'b0);

    // Flush ordering: wb before clear
    wr(32'h0, 32'h0007_0000);
    check("flush_e0", 32'(cmd), NOP);
    tick();
    check("flush_wb", 32'(cmd), WB);
    rd("flush_status", 32'h4, 32'h0000_003B);
    ready_pulse();
    check("flush_idle", 32'(cmd), NOP);
    tick();
    check("flush_clr", 32'(cmd), CLR);
    ready_pulse();
    check("flush_nop", 32'(cmd), NOP);
    tick();
    check("flush_quiet", 32'(cmd), NOP);

    // Disabling implies clear
    wr(32'h0, 32'h0000_0000);
    check("dis_en", 32'(isEnableCache), 32'd0);
    check("dis_e0", 32'(cmd), NOP);
    tick();
    check("dis_clr", 32'(cmd), CLR);
    ready_pulse();
    wr(32'h0, 32'h0001_0000);
    check("reen_en", 32'(isEnableCache), 32'd1);
    tick();
    check("reen_nocmd", 32'(cmd), NOP);
    rd("ctrl_rb", 32'h0, 32'h0001_0000);

    // Queue merge during WAIT
    wr(32'h0, 32'h0003_0000);
    tick();
    check("merge_wb1", 32'(cmd), WB);
    wr(32'h0, 32'h0003_0000);
    wr(32'h0, 32'h0003_0000);
    wr(32'h0, 32'h0005_0000);
    rd("merge_status", 32'h4, 32'h0000_003F);
    ready_pulse();
    check("merge_idle1", 32'(cmd), NOP);
    tick();
    check("merge_wb2", 32'(cmd), WB);
    ready_pulse();
    tick();
    check("merge_clr", 32'(cmd), CLR);
    ready_pulse();
    tick();
    check("merge_end", 32'(cmd), NOP);

    // Request in the consume cycle re-arms the pend bit
    s0_address = 32'h0; s0_writeData = 32'h0003_0000; s0_write = 1'b1;
    tick(); tick();
    s0_write = 1'b0;
    check("rearm_wb", 32'(cmd), WB);
    rd("rearm_status", 32'h4, 32'h0000_0037);
    ready_pulse();
    tick();
    check("rearm_wb2", 32'(cmd), WB);
    ready_pulse();
    tick();

    // cmd_ready while IDLE is ignored
    ready_pulse();
    check("idle_ready", 32'(cmd), NOP);

    // Bus behaviour
    rd("unmapped_28", 32'h28, 32'h0);
    rd("unmapped_3c", 32'h3C, 32'h0);
    s0_address = 32'h0C; s0_writeData = 32'h0000_0400; s0_write = 1'b1; s0_read = 1'b1;
    tick();
    s0_write = 1'b0; s0_read = 1'b0;
    check("rw_same_old", s0_readData, 32'h0);
    rd("rw_same_new", 32'h0C, 32'h0000_0400);
    wr(32'h4, 32'h0000_0002);
    rd("done_w1c", 32'h4, 32'h0000_0000);

    // Reset mid-command drops pending work
    wr(32'h0, 32'h0003_0000);
    tick();
    wr(32'h0, 32'h0005_0000);
    check("abort_pre", 32'(cmd), WB);
    rest = 1'b1;
    tick();
    rest = 1'b0;
    check("abort_cmd", 32'(cmd), INI);
    rd("abort_status", 32'h4, 32'h0000_0011);
    io("abort_region", 32'h0000_1000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
